cache_sram_peek: RTL and testbench

Wishbone-slave controller that owns the otherwise idle second (read-only) port of the cache SRAM macros: the tag-array pair and the data_arrays_0_0 bank set. It lets the management core read any cache word non-intrusively while the Marmot core runs, by sequencing `csb1`/`addr1` and capturing read data. It sits beside the reset/control register on the user-project Wishbone bus, and its outputs replace the constant port-1 tie-offs.

---
 rtl/cache_sram_pkg.sv | 42 ++++
 rtl/sram_collision_chk.sv | 14 +
 rtl/cache_sram_peek.sv | 188 ++++++++++++++++++
 tb/tb_cache_sram_peek.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_sram_pkg.sv
// Shared types and geometry for the cache SRAM port-1 peek controller.
// Offsets are relative to the 32 KiB Wishbone window.
package cache_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_ACK     = 2'd3
  } state_e;

  localparam int WIN_LSB = 15;

  // Window offset fields: bit 14 picks the array, the rest depend on it
  localparam int OFF_ARR_BIT   = 14;
  localparam int OFF_BANK_HI   = 13;
  localparam int OFF_BANK_LO   = 12;
  localparam int OFF_DROW_HI   = 11;
  localparam int OFF_DROW_LO   = 3;
  localparam int OFF_HALF_BIT  = 2;
  localparam int OFF_MACRO_BIT = 10;
  localparam int OFF_TROW_HI   = 9;
  localparam int OFF_TROW_LO   = 2;

  localparam int TAG_ROWS        = 256;
  localparam int DATA_ROWS       = 512;
  localparam int DATA_BANKS      = 4;
  localparam int MACROS_PER_BANK = 2;
  localparam int TAG_AW          = $clog2(TAG_ROWS);
  localparam int DATA_AW         = $clog2(DATA_ROWS);
  localparam int DATA_CSB_W      = DATA_BANKS * MACROS_PER_BANK;

  // Both macros of a bank hold one 64-bit word, so they are enabled together
  function automatic logic [DATA_CSB_W-1:0] data_csb_mask(input logic [1:0] bank);
    return ~(DATA_CSB_W'(2'b11) << {bank, 1'b0});
  endfunction

  function automatic logic [1:0] tag_csb_mask(input logic macro);
    return ~(2'b01 << macro);
  endfunction

endpackage

// File: rtl/sram_collision_chk.sv
// Flags a port-0 write hitting the row that port 1 is about to read.
module sram_collision_chk #(
  parameter int AW = 8
) (
  input  logic          csb0_i,
  input  logic          web0_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [AW-1:0] row_i,
  output logic          hit_o
);

  assign hit_o = ~csb0_i & ~web0_i & (addr0_i == row_i);

endmodule

// File: rtl/cache_sram_peek.sv
// Wishbone slave that reads cache tag/data words through the idle SRAM port 1,
// stalling the launch while port 0 writes the same row.
module cache_sram_peek
  import cache_sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_8000,
  parameter int          RETRY_LIMIT = 15
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [31:0]           wbs_adr_i,
  output logic [31:0]           wbs_dat_o,
  output logic                  wbs_ack_o,
  input  logic                  tag_csb0,
  input  logic                  tag_web0,
  input  logic [TAG_AW-1:0]     tag_addr0,
  input  logic [DATA_BANKS-1:0] data_csb0,
  input  logic                  data_web0,
  input  logic [DATA_AW-1:0]    data_addr0,
  output logic [1:0]            tag_csb1,
  output logic [TAG_AW-1:0]     tag_addr1,
  input  logic [31:0]           tag_rdata0,
  input  logic [31:0]           tag_rdata1,
  output logic [DATA_CSB_W-1:0] data_csb1,
  output logic [DATA_AW-1:0]    data_addr1,
  input  logic [63:0]           data_rdata0,
  input  logic [63:0]           data_rdata1,
  input  logic [63:0]           data_rdata2,
  input  logic [63:0]           data_rdata3
);

  localparam int RW = (RETRY_LIMIT < 1) ? 1 : $clog2(RETRY_LIMIT + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(RETRY_LIMIT);

  state_e              state_q, state_d;
  logic [RW-1:0]       retry_q, retry_d;
  logic                is_tag_q, is_tag_d;
  logic [1:0]          sel_q, sel_d;
  logic                half_q, half_d;
  logic [31:0]         dat_q, dat_d;
  logic [TAG_AW-1:0]   tag_addr1_q, tag_addr1_d;
  logic [DATA_AW-1:0]  data_addr1_q, data_addr1_d;

  logic                win_hit;
  logic                req_tag, req_half, req_macro;
  logic [1:0]          req_bank;
  logic [DATA_AW-1:0]  req_drow;
  logic [TAG_AW-1:0]   req_trow;
  logic                data_coll, tag_coll, collide;
  logic [63:0]         bank_rd;
  logic [31:0]         data_slice, tag_slice;
  logic                unused_adr;

  assign win_hit   = wbs_cyc_i & wbs_stb_i &
                     (wbs_adr_i[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
  assign req_tag   = wbs_adr_i[OFF_ARR_BIT];
  assign req_bank  = wbs_adr_i[OFF_BANK_HI:OFF_BANK_LO];
  assign req_drow  = wbs_adr_i[OFF_DROW_HI:OFF_DROW_LO];
  assign req_half  = wbs_adr_i[OFF_HALF_BIT];
  assign req_macro = wbs_adr_i[OFF_MACRO_BIT];
  assign req_trow  = wbs_adr_i[OFF_TROW_HI:OFF_TROW_LO];
  assign unused_adr = ^wbs_adr_i[1:0];

  // Port-0 compare against the row already latched into addr1
  sram_collision_chk #(.AW(DATA_AW)) u_data_chk (
    .csb0_i  (data_csb0[sel_q]),
    .web0_i  (data_web0),
    .addr0_i (data_addr0),
    .row_i   (data_addr1_q),
    .hit_o   (data_coll)
  );

  sram_collision_chk #(.AW(TAG_AW)) u_tag_chk (
    .csb0_i  (tag_csb0),
    .web0_i  (tag_web0),
    .addr0_i (tag_addr0),
    .row_i   (tag_addr1_q),
    .hit_o   (tag_coll)
  );

  assign collide = is_tag_q ? tag_coll : data_coll;

  always_comb begin
    bank_rd = data_rdata0;
    unique case (sel_q)
      2'd0: bank_rd = data_rdata0;
      2'd1: bank_rd = data_rdata1;
      2'd2: bank_rd = data_rdata2;
      2'd3: bank_rd = data_rdata3;
      default: bank_rd = data_rdata0;
    endcase
  end

  assign data_slice = half_q ? bank_rd[63:32] : bank_rd[31:0];
  assign tag_slice  = sel_q[0] ? tag_rdata1 : tag_rdata0;

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    is_tag_d     = is_tag_q;
    sel_d        = sel_q;
    half_d       = half_q;
    dat_d        = dat_q;
    tag_addr1_d  = tag_addr1_q;
    data_addr1_d = data_addr1_q;
    tag_csb1     = '1;
    data_csb1    = '1;
    unique case (state_q)
      ST_IDLE: begin
        if (win_hit) begin
          if (wbs_we_i) begin
            dat_d   = '0;
            state_d = ST_ACK;
          end else begin
            is_tag_d = req_tag;
            half_d   = req_half;
            if (req_tag) begin
              sel_d       = {1'b0, req_macro};
              tag_addr1_d = req_trow;
            end else begin
              sel_d        = req_bank;
              data_addr1_d = req_drow;
            end
            state_d = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: begin
        if (!wbs_cyc_i) begin
          retry_d = '0;
          state_d = ST_IDLE;
        end else if (collide && (retry_q != RETRY_MAX)) begin
          retry_d = retry_q + RW'(1);
        end else begin
          // Forced launch after RETRY_LIMIT stalls reads whatever the macro returns
          if (is_tag_q) tag_csb1  = tag_csb_mask(sel_q[0]);
          else          data_csb1 = data_csb_mask(sel_q);
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (!wbs_cyc_i) begin
          retry_d = '0;
          state_d = ST_IDLE;
        end else begin
          dat_d   = is_tag_q ? tag_slice : data_slice;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        retry_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      retry_q      <= '0;
      is_tag_q     <= 1'b0;
      sel_q        <= '0;
      half_q       <= 1'b0;
      dat_q        <= '0;
      tag_addr1_q  <= '0;
      data_addr1_q <= '0;
    end else begin
      state_q      <= state_d;
      retry_q      <= retry_d;
      is_tag_q     <= is_tag_d;
      sel_q        <= sel_d;
      half_q       <= half_d;
      dat_q        <= dat_d;
      tag_addr1_q  <= tag_addr1_d;
      data_addr1_q <= data_addr1_d;
    end
  end

  assign wbs_ack_o  = (state_q == ST_ACK);
  assign wbs_dat_o  = dat_q;
  assign tag_addr1  = tag_addr1_q;
  assign data_addr1 = data_addr1_q;

endmodule

// File: tb/tb_cache_sram_peek.sv
// Randomized bench for cache_sram_peek with behavioural SRAM and latency model.
module tb_cache_sram_peek;

  localparam logic [31:0] BASE = 32'h3000_8000;
  localparam int          RL   = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [31:0] adr;
  logic [31:0] dat_o;
  logic        ack;
  logic        tag_csb0, tag_web0;
  logic [7:0]  tag_addr0;
  logic [3:0]  data_csb0;
  logic        data_web0;
  logic [8:0]  data_addr0;
  logic [1:0]  tag_csb1;
  logic [7:0]  tag_addr1;
  logic [7:0]  data_csb1;
  logic [8:0]  data_addr1;

  logic [63:0] data_mem [4][512];
  logic [31:0] tag_mem  [2][256];
  logic [63:0] drd [4];
  logic [31:0] trd [2];

  int n_chk = 0;
  int n_fail = 0;
  logic [8:0] exp_daddr;
  logic [7:0] exp_taddr;

  always #5 clk = ~clk;

  cache_sram_peek #(.BASE_ADDR(BASE), .RETRY_LIMIT(RL)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_adr_i(adr),
    .wbs_dat_o(dat_o), .wbs_ack_o(ack),
    .tag_csb0(tag_csb0), .tag_web0(tag_web0), .tag_addr0(tag_addr0),
    .data_csb0(data_csb0), .data_web0(data_web0), .data_addr0(data_addr0),
    .tag_csb1(tag_csb1), .tag_addr1(tag_addr1),
    .tag_rdata0(trd[0]), .tag_rdata1(trd[1]),
    .data_csb1(data_csb1), .data_addr1(data_addr1),
    .data_rdata0(drd[0]), .data_rdata1(drd[1]),
    .data_rdata2(drd[2]), .data_rdata3(drd[3])
  );

  // SRAM port-1 model: word appears the cycle after csb1 low, garbage otherwise
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      drd[b] <= !data_csb1[2*b] ? data_mem[b][data_addr1] : {$urandom, $urandom};
    for (int m = 0; m < 2; m++)
      trd[m] <= !tag_csb1[m] ? tag_mem[m][tag_addr1] : $urandom;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic port0_idle();
    tag_csb0 = 1'b1; tag_web0 = 1'b1; tag_addr0 = '0;
    data_csb0 = 4'hF; data_web0 = 1'b1; data_addr0 = '0;
  endtask

  // Port-0 traffic for cycle c: a same-row write in cycles 1..ncoll, else harmless noise
  task automatic set_port0(input int c, input logic [31:0] a, input int ncoll);
    logic [1:0] bank;
    logic [8:0] drow;
    logic [7:0] trow;
    bank = a[13:12]; drow = a[11:3]; trow = a[9:2];
    tag_csb0 = 1'($urandom); tag_web0 = 1'($urandom); tag_addr0 = 8'($urandom);
    data_csb0 = 4'($urandom); data_web0 = 1'($urandom); data_addr0 = 9'($urandom);
    if (c >= 1 && c <= ncoll) begin
      if (a[14]) begin
        tag_csb0 = 1'b0; tag_web0 = 1'b0; tag_addr0 = trow;
      end else begin
        data_csb0 = ~(4'b0001 << bank); data_web0 = 1'b0; data_addr0 = drow;
      end
    end else begin
      if (tag_addr0 == trow) tag_addr0 = trow ^ 8'h01;
      if (data_addr0 == drow) data_addr0 = drow ^ 9'h001;
      if ($urandom_range(0, 3) == 0) begin
        data_addr0 = drow; data_web0 = 1'b0; data_csb0 = 4'hF ^ (4'b0001 << (bank ^ 2'd1));
        tag_addr0 = trow; tag_web0 = 1'b1; tag_csb0 = 1'b0;
      end
    end
  endtask

  task automatic run_txn(input logic w, input logic [31:0] a, input int ncoll);
    bit         in_win, is_tag;
    int         exp_lat, got_lat, budget, pulses, nc;
    logic [31:0] exp_dat, got_dat;
    logic [63:0] word;
    logic [7:0]  got_dcsb, exp_dcsb;
    logic [1:0]  got_tcsb, exp_tcsb;
    logic [8:0]  got_da;
    logic [7:0]  got_ta;
    in_win = (a[31:15] == BASE[31:15]);
    is_tag = a[14];
    nc = (ncoll > RL) ? RL : ncoll;
    exp_lat = !in_win ? -1 : (w ? 1 : 3 + nc);
    word = data_mem[a[13:12]][a[11:3]];
    exp_dat = w ? 32'h0 : (is_tag ? tag_mem[a[10]][a[9:2]] : (a[2] ? word[63:32] : word[31:0]));
    exp_dcsb = 8'hFF; exp_tcsb = 2'b11;
    if (in_win && !w) begin
      if (is_tag) begin exp_tcsb = ~(2'b01 << a[10]); exp_taddr = a[9:2]; end
      else begin exp_dcsb = ~(8'b0000_0011 << (2 * a[13:12])); exp_daddr = a[11:3]; end
    end
    budget = (exp_lat < 0) ? 10 : exp_lat + 3;
    got_lat = -1; got_dat = '0; pulses = 0;
    got_dcsb = 8'hFF; got_tcsb = 2'b11; got_da = '0; got_ta = '0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a;
    set_port0(0, a, ncoll);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (data_csb1 != 8'hFF || tag_csb1 != 2'b11) begin
        pulses++; got_dcsb = data_csb1; got_tcsb = tag_csb1;
        got_da = data_addr1; got_ta = tag_addr1;
      end
      if (ack) begin got_lat = c; got_dat = dat_o; break; end
      @(posedge clk); #1;
      set_port0(c + 1, a, ncoll);
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    port0_idle();
    @(negedge clk);
    chk("ack_lat", 64'(got_lat), 64'(exp_lat));
    chk("ack_one_cycle", 64'(ack), 64'(0));
    if (in_win) chk("rdata", 64'(got_dat), 64'(exp_dat));
    chk("csb1_pulses", 64'(pulses), 64'((in_win && !w) ? 1 : 0));
    if (in_win && !w) begin
      chk("data_csb1", 64'(got_dcsb), 64'(exp_dcsb));
      chk("tag_csb1", 64'(got_tcsb), 64'(exp_tcsb));
      if (is_tag) chk("tag_addr1", 64'(got_ta), 64'(a[9:2]));
      else        chk("data_addr1", 64'(got_da), 64'(a[11:3]));
    end
    chk("data_addr1_hold", 64'(data_addr1), 64'(exp_daddr));
    chk("tag_addr1_hold", 64'(tag_addr1), 64'(exp_taddr));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_data_csb1"}, 64'(data_csb1), 64'hFF);
    chk({tag, "_tag_csb1"}, 64'(tag_csb1), 64'h3);
    chk({tag, "_ack"}, 64'(ack), 64'h0);
    chk({tag, "_dat"}, 64'(dat_o), 64'h0);
    chk({tag, "_data_addr1"}, 64'(data_addr1), 64'h0);
    chk({tag, "_tag_addr1"}, 64'(tag_addr1), 64'h0);
  endtask

  initial begin
    int acks, pulses, kind, nc;
    logic [31:0] a;
    for (int b = 0; b < 4; b++)
      for (int r = 0; r < 512; r++) data_mem[b][r] = {$urandom, $urandom};
    for (int m = 0; m < 2; m++)
      for (int r = 0; r < 256; r++) tag_mem[m][r] = $urandom;
    data_mem[1][9'h148] = 64'h1122_3344_5566_7788;
    exp_daddr = '0; exp_taddr = '0;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0;
    port0_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases
    run_txn(1'b0, BASE | 32'h1A44, 0);
    chk("directed_rdata", 64'(dat_o), 64'h1122_3344);
    run_txn(1'b0, BASE | 32'h45FC, 0);
    run_txn(1'b0, BASE | 32'h1A44, 3);
    run_txn(1'b0, BASE | 32'h1A44, 20);
    run_txn(1'b0, BASE | 32'h45FC, 4);
    run_txn(1'b1, BASE | 32'h0124, 0);
    run_txn(1'b0, 32'h3001_0000 | 32'h1A44, 0);
    run_txn(1'b1, 32'h2000_8000, 0);

    // Abort in LAUNCH
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE | 32'h2A08;
    exp_daddr = 9'h141;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    acks = 0; pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ack) acks++;
      if (data_csb1 != 8'hFF || tag_csb1 != 2'b11) pulses++;
    end
    chk("abort_ack", 64'(acks), 64'h0);
    chk("abort_csb1", 64'(pulses), 64'h0);
    run_txn(1'b0, BASE | 32'h3FFC, 0);

    // Reset during CAPTURE
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE | 32'h4004;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    exp_daddr = '0; exp_taddr = '0;
    @(negedge clk);
    check_reset_vals("rst_capture");
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    chk("rst_capture_noack", 64'(acks), 64'h0);

    // Random traffic
    for (int i = 0; i < 50; i++) begin
      kind = $urandom_range(0, 9);
      a = {BASE[31:15], 15'($urandom)};
      nc = 0;
      if ($urandom_range(0, 2) == 0) nc = $urandom_range(1, 5);
      if ($urandom_range(0, 9) == 0) nc = $urandom_range(14, 18);
      if (kind == 0) begin
        run_txn(1'b1, a, 0);
      end else if (kind == 1) begin
        a[31:15] = a[31:15] ^ 17'($urandom_range(1, 131071));
        run_txn(1'($urandom), a, 0);
      end else begin
        run_txn(1'b0, a, nc);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
